// File: rtl/counter_mod_ud.sv
// counter_mod_ud: up/down modulo-MOD counter with clear, load, enable and cascade tc.
// Define COUNTER_MOD_UD_SAT_EN to saturate at the range ends instead of wrapping.
module counter_mod_ud #(
    parameter int N   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] din,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         wrap
);
    if (MOD < 2 || MOD > (2 ** N)) begin : g_bad_mod
        $error("counter_mod_ud: MOD must lie in 2..2**N");
    end
    // One extra bit so MOD = 2**N still compares correctly against MOD-1.
    localparam logic [N:0] LAST = (N+1)'(MOD - 1);
    logic [N-1:0] r_count;
    logic [N-1:0] w_next;
    logic [N-1:0] w_step;
    logic [N-1:0] w_load;
    logic         w_at_term;
    always_comb begin
        w_at_term = up ? ({1'b0, r_count} == LAST) : (r_count == '0);
        tc        = en & ~clr & ~load & w_at_term;
        w_load    = ({1'b0, din} > LAST) ? LAST[N-1:0] : din;
`ifdef COUNTER_MOD_UD_SAT_EN
        w_step    = w_at_term ? r_count : (up ? r_count + 1'b1 : r_count - 1'b1);
`else
        w_step    = w_at_term ? (up ? '0 : LAST[N-1:0]) : (up ? r_count + 1'b1 : r_count - 1'b1);
`endif
        w_next    = clr ? '0 : load ? w_load : en ? w_step : r_count;
    end
`ifdef COUNTER_MOD_UD_SAT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_count <= '0;
        else         r_count <= w_next;
    end
    assign wrap = 1'b0;
`else
    logic r_wrap;
    // A boundary-crossing step happens exactly when tc is high at the edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= tc;
        end
    end
    assign wrap = r_wrap;
`endif
    assign count = r_count;
endmodule

// File: tb/tb_counter_mod_ud.sv
// tb_counter_mod_ud: random and directed checks of counter_mod_ud (N=4, MOD=10)
// against an arithmetic reference model, plus a two-stage decimal cascade.
module tb_counter_mod_ud;
    localparam int N   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1;
    logic [N-1:0] din = '0;
    logic [N-1:0] count;
    logic         tc, wrap;

    logic         c_en = 1'b0;
    logic [N-1:0] c_cnt0, c_cnt1;
    logic         c_tc0, c_tc1, c_wrap0, c_wrap1;

    int n_chk = 0;
    int n_err = 0;
    int m_cnt = 0;
    bit m_wrap = 1'b0;

    always #5 clk = ~clk;

    counter_mod_ud #(.N(N), .MOD(MOD)) u_dut (
        .clk(clk), .arst_n(arst_n), .clr(clr), .load(load), .din(din),
        .en(en), .up(up), .count(count), .tc(tc), .wrap(wrap)
    );

    counter_mod_ud #(.N(N), .MOD(MOD)) u_s0 (
        .clk(clk), .arst_n(arst_n), .clr(1'b0), .load(1'b0), .din('0),
        .en(c_en), .up(1'b1), .count(c_cnt0), .tc(c_tc0), .wrap(c_wrap0)
    );

    counter_mod_ud #(.N(N), .MOD(MOD)) u_s1 (
        .clk(clk), .arst_n(arst_n), .clr(1'b0), .load(1'b0), .din('0),
        .en(c_tc0), .up(1'b1), .count(c_cnt1), .tc(c_tc1), .wrap(c_wrap1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_tc(input int m, input bit c, input bit l, input bit e, input bit u);
        return e && !c && !l && (u ? (m == MOD - 1) : (m == 0));
    endfunction

    // Reference behaviour straight from the priority rules, in plain integers.
    function automatic void m_step(input int m, input bit c, input bit l, input bit e,
                                   input bit u, input int d, output int mn, output bit wn);
        mn = m;
        wn = 1'b0;
        if (c) mn = 0;
        else if (l) mn = (d > MOD - 1) ? MOD - 1 : d;
        else if (e) begin
            if (u) mn = m + 1;
            else   mn = m - 1;
`ifdef COUNTER_MOD_UD_SAT_EN
            if (mn >= MOD) mn = MOD - 1;
            if (mn < 0)    mn = 0;
`else
            if (mn >= MOD) begin mn = 0;       wn = 1'b1; end
            if (mn < 0)    begin mn = MOD - 1; wn = 1'b1; end
`endif
        end
    endfunction

    task automatic tick(input string tag);
        int  mn;
        bit  wn;
        #1 chk({tag, ".tc"}, 32'(tc), 32'(m_tc(m_cnt, clr, load, en, up)));
        m_step(m_cnt, clr, load, en, up, int'(din), mn, wn);
        @(posedge clk);
        m_cnt  = mn;
        m_wrap = wn;
        #1;
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
    endtask

    task automatic drive(input bit c, input bit l, input bit e, input bit u, input int d);
        clr  = c;
        load = l;
        en   = e;
        up   = u;
        din  = N'(d);
    endtask

    initial begin
        int c0, c1, c0n, c1n;
        bit w0, w1, t0;
        #12;
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.wrap",  32'(wrap),  32'd0);
        chk("reset.tc",    32'(tc),    32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Count up through the wrap.
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) tick("up");
        // Load 1, then count down through the wrap.
        drive(0, 1, 0, 0, 1);
        tick("load1");
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick("down");
        // Priority and clamp.
        drive(1, 1, 1, 1, 5);
        tick("clr_prio");
        drive(0, 1, 0, 1, 13);
        tick("clamp");
        drive(0, 1, 1, 1, 7);
        tick("load_over_en");
        drive(0, 1, 1, 1, 15);
        tick("clamp_en");
        drive(0, 0, 1, 1, 0);
        tick("at_max_up");
        drive(0, 1, 0, 0, 0);
        tick("load0");
        drive(0, 0, 1, 0, 0);
        tick("at_zero_down");
        drive(0, 0, 0, 1, 0);
        tick("hold");

        // Asynchronous reset between edges.
        drive(0, 1, 0, 1, 6);
        tick("load6");
        drive(0, 0, 0, 1, 0);
        #2 arst_n = 1'b0;
        #1;
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.wrap",  32'(wrap),  32'd0);
        m_cnt  = 0;
        m_wrap = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        drive(0, 0, 1, 1, 0);
        tick("post_arst");

        // Randomized mix of all controls.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 15)));
            tick("rand");
        end
        drive(0, 0, 0, 1, 0);

        // Two-stage decimal cascade; stage 1 is enabled by stage 0's tc.
        arst_n = 1'b0;
        #1;
        chk("cas.reset", 32'(c_cnt0 + 10 * c_cnt1), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        c0 = 0;
        c1 = 0;
        c_en = 1'b1;
        for (int i = 0; i < 101; i++) begin
            #1;
            t0 = m_tc(c0, 0, 0, 1, 1);
            chk("cas.tc0", 32'(c_tc0), 32'(t0));
            m_step(c0, 0, 0, 1, 1, 0, c0n, w0);
            m_step(c1, 0, 0, t0, 1, 0, c1n, w1);
            @(posedge clk);
            c0 = c0n;
            c1 = c1n;
            #1;
            chk("cas.value", 32'(c_cnt0 + 10 * c_cnt1), 32'(c0 + 10 * c1));
            chk("cas.wrap1", 32'(c_wrap1), 32'(w1));
        end
        c_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/counter_mod_ud.md
# counter_mod_ud

Parametrised synchronous up/down modulo counter with synchronous clear, parallel load, count enable and a cascade-ready terminal-count output. It generalises the free-running binary counter into the counting primitive for timers, decade and BCD chains, and address sequencers. Several instances can be chained through `tc`/`en` to build wider counters or mixed-radix counters.

## Interface

Parameters:
- `N`, default 4: counter width in bits.
- `MOD`, default 16: modulus. The count range is 0..MOD-1. Legal values are 2 ≤ MOD ≤ 2^N; any other value is an elaboration error.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `arst_n`  in  1: reset, asynchronous, active-low.
- `clr`  in  1: synchronous clear.
- `load`  in  1: synchronous parallel load of `din`.
- `din`  in  N: load value.
- `en`  in  1: count enable.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `count`  out  N: current count, registered.
- `tc`  out  1: terminal count, combinational. Used for cascading.
- `wrap`  out  1: registered one-cycle pulse, asserted in the cycle after `count` wraps.

## Operation

- **Reset.** While `arst_n` = 0, `count` = 0 and `wrap` = 0. Reset acts immediately and is independent of `clk`. If reset asserts mid-count, the count is lost, and `count` resumes from 0 on the first edge after release.
- **Priority per rising edge:** `clr` > `load` > `en` > hold.
  - `clr`: `count` ← 0.
  - `load`: `count` ← `din` if `din` ≤ MOD-1, otherwise `count` ← MOD-1 (clamped).
  - `en` with `up` = 1: `count` ← `count`+1. When `count` = MOD-1, `count` ← 0.
  - `en` with `up` = 0: `count` ← `count`-1. When `count` = 0, `count` ← MOD-1.
  - Otherwise `count` holds.
- **Arithmetic.** Computed at N+1 bits internally, so MOD = 2^N never overflows the compare.
- **`wrap`.** Set to 1 on an edge where an `en` step crosses the boundary (MOD-1→0 up, or 0→MOD-1 down). Set to 0 on every other edge, including `clr` and `load` edges.
- **Terminal condition `at_term`.**
  - `up` = 1: `count` = MOD-1.
  - `up` = 0: `count` = 0.
- **`tc`.** `tc` = `en` & ~`clr` & ~`load` & `at_term`.
- **Cascading.** Drive the next stage's `en` from this stage's `tc`, with shared `up`, `clr` and `clk`.
- **Direction change.** Changing `up` takes effect on the next edge and needs no settling cycle. `tc` follows `up` combinationally.
- **`load` with `en`.** When `load` and `en` are both high, `load` wins. No step occurs and `wrap` = 0.

## Timing

- `count` and `wrap` have one-cycle latency from the inputs sampled at a rising edge.
- `tc` has zero latency: it is valid in the same cycle as `count` and its inputs.
- Cascade path: the critical path is `count` → `at_term` → `tc` → next-stage `en` → register. The chain depth is the designer's responsibility.
- The first edge after `arst_n` deasserts may be used. No synchronous reset-release handling is inside the block.

## Configuration

- Macro: `COUNTER_MOD_UD_SAT_EN`.
- **Defined:** the counter saturates instead of wrapping.
  - Up at MOD-1 holds MOD-1.
  - Down at 0 holds 0.
  - `wrap` is tied to 0.
  - `tc` is unchanged (it still flags the terminal value, so a saturated counter keeps `tc` high while `en` is high).
- **Undefined (default):** modulo wrap behaviour as described in Operation.

## Test plan

All scenarios use N=4, MOD=10 unless stated.

1. Reset then count: `arst_n` low, then release with `en`=1, `up`=1 for 12 edges → `count` sequence 1..9, 0, 1, 2. `wrap` = 1 only in the cycle after 9→0. `tc` = 1 only while `count` = 9.
2. Down wrap: `load` `din`=1, then `en`=1, `up`=0 → `count` goes 1, 0, 9, 8. `wrap` pulses once after 0→9. `tc` = 1 while `count` = 0.
3. Priority and clamp:
   - `clr`=1, `load`=1, `din`=5, `en`=1 → `count`=0.
   - Then `load`=1, `din`=13 → `count`=9, with `tc`=0 in the `load` cycle.
   - Then `load`=1, `din`=7, `en`=1 → `count`=7 (no increment), `wrap`=0.
4. Async reset mid-count: at `count`=6, pulse `arst_n` low between edges → `count`=0 and `wrap`=0 immediately, before the next edge.
5. Cascade: two instances (MOD=10 each), stage-1 `en` driven by stage-0 `tc`, 100 enabled edges → the pair reads 00..99 then 00. Stage 1 steps only on the stage-0 9→0 edges.
6. With `COUNTER_MOD_UD_SAT_EN` defined:
   - 12 up-steps from 0 → `count` stays 9 and `wrap` stays 0 throughout.
   - 3 down-steps from 1 → `count` goes 0, 0, 0.
